// File: rtl/ball_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : ball_ctrl
//  Brief   : Pong ball position/direction state machine with score pulses and
//            a registered ball-tile draw flag for the video scan.
//  Revision: 1.0
// ============================================================================
module ball_ctrl #(
  parameter int BOARD_WIDTH   = 40,
  parameter int BOARD_HEIGHT  = 30,
  parameter int PADDLE_HEIGHT = 6,
  parameter int BALL_SPEED    = 1250000
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_game_active,
  input  logic [5:0] i_paddle_y1,
  input  logic [5:0] i_paddle_y2,
  input  logic [5:0] i_col_counter_div,
  input  logic [5:0] i_row_counter_div,
  output logic [5:0] o_ball_x,
  output logic [5:0] o_ball_y,
  output logic       o_draw_ball,
  output logic       o_p1_score,
  output logic       o_p2_score
);

  localparam int               c_cnt_w       = (BALL_SPEED > 1) ? $clog2(BALL_SPEED) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max   = c_cnt_w'(BALL_SPEED - 1);
  localparam logic [5:0]       c_x_centre    = 6'(BOARD_WIDTH / 2);
  localparam logic [5:0]       c_y_centre    = 6'(BOARD_HEIGHT / 2);
  localparam logic [5:0]       c_x_max       = 6'(BOARD_WIDTH - 1);
  localparam logic [5:0]       c_x_p2_front  = 6'(BOARD_WIDTH - 2);
  localparam logic [5:0]       c_x_p2_bounce = 6'(BOARD_WIDTH - 3);
  localparam logic [5:0]       c_y_max       = 6'(BOARD_HEIGHT - 1);
  localparam logic [5:0]       c_y_bounce    = 6'(BOARD_HEIGHT - 2);
  localparam logic [6:0]       c_paddle_h    = 7'(PADDLE_HEIGHT);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_MOVING = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
  logic [5:0]         r_x, w_x_nxt;
  logic [5:0]         r_y, w_y_nxt;
  logic               r_dir_x, w_dir_x_nxt;
  logic               r_dir_y, w_dir_y_nxt;
  logic               r_p1, w_p1_nxt;
  logic               r_p2, w_p2_nxt;
  logic               r_draw;
  logic               w_hit1, w_hit2;

  // Paddle overlap uses the pre-step row; 7-bit compare avoids top+height wrap.
  assign w_hit1 = ({1'b0, r_y} >= {1'b0, i_paddle_y1}) &&
                  ({1'b0, r_y} <  ({1'b0, i_paddle_y1} + c_paddle_h));
  assign w_hit2 = ({1'b0, r_y} >= {1'b0, i_paddle_y2}) &&
                  ({1'b0, r_y} <  ({1'b0, i_paddle_y2} + c_paddle_h));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_dir_x_nxt = r_dir_x;
    w_dir_y_nxt = r_dir_y;
    w_p1_nxt    = 1'b0;
    w_p2_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_x_nxt   = c_x_centre;
        w_y_nxt   = c_y_centre;
        w_cnt_nxt = '0;
        if (i_game_active) w_state_nxt = S_MOVING;
      end
      S_MOVING: begin
        if (!i_game_active) begin
          w_state_nxt = S_IDLE;
          w_x_nxt     = c_x_centre;
          w_y_nxt     = c_y_centre;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_cnt_max) begin
          w_cnt_nxt = '0;
          if (r_dir_y) begin
            if (r_y == c_y_max) begin
              w_dir_y_nxt = 1'b0;
              w_y_nxt     = c_y_bounce;
            end else begin
              w_y_nxt = r_y + 6'd1;
            end
          end else begin
            if (r_y == 6'd0) begin
              w_dir_y_nxt = 1'b1;
              w_y_nxt     = 6'd1;
            end else begin
              w_y_nxt = r_y - 6'd1;
            end
          end

          if (r_dir_x) begin
            if (r_x == c_x_max) begin
              w_p1_nxt = 1'b1;
            end else if (r_x == c_x_p2_front && w_hit2) begin
              w_dir_x_nxt = 1'b0;
              w_x_nxt     = c_x_p2_bounce;
            end else begin
              w_x_nxt = r_x + 6'd1;
            end
          end else begin
            if (r_x == 6'd0) begin
              w_p2_nxt = 1'b1;
            end else if (r_x == 6'd1 && w_hit1) begin
              w_dir_x_nxt = 1'b1;
              w_x_nxt     = 6'd2;
            end else begin
              w_x_nxt = r_x - 6'd1;
            end
          end

          // A score discards the step and serves toward the scorer.
          if (w_p1_nxt || w_p2_nxt) begin
            w_state_nxt = S_IDLE;
            w_x_nxt     = c_x_centre;
            w_y_nxt     = c_y_centre;
            w_dir_y_nxt = r_dir_y;
            w_dir_x_nxt = w_p2_nxt;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_x     <= c_x_centre;
      r_y     <= c_y_centre;
      r_dir_x <= 1'b1;
      r_dir_y <= 1'b1;
      r_p1    <= 1'b0;
      r_p2    <= 1'b0;
      r_draw  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_dir_x <= w_dir_x_nxt;
      r_dir_y <= w_dir_y_nxt;
      r_p1    <= w_p1_nxt;
      r_p2    <= w_p2_nxt;
      r_draw  <= (i_col_counter_div == r_x) && (i_row_counter_div == r_y);
    end
  end

  assign o_ball_x    = r_x;
  assign o_ball_y    = r_y;
  assign o_draw_ball = r_draw;
  assign o_p1_score  = r_p1;
  assign o_p2_score  = r_p2;

endmodule
`default_nettype wire

// File: tb/tb_ball_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ball_ctrl
//  Brief   : Directed start-up sequence followed by randomized play checked
//            against a ball-trajectory reference model.
//  Revision: 1.0
// ============================================================================
module tb_ball_ctrl;

  localparam int W     = 40;
  localparam int H     = 30;
  localparam int PH    = 6;
  localparam int SPEED = 4;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_game_active;
  logic [5:0] i_paddle_y1, i_paddle_y2;
  logic [5:0] i_col_counter_div, i_row_counter_div;
  logic [5:0] o_ball_x, o_ball_y;
  logic       o_draw_ball, o_p1_score, o_p2_score;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: integer position, signed unit velocity, phase in a step.
  int mx, my, mdx, mdy, mphase;
  bit mmoving, mp1, mp2, mdraw;
  int mod_p1_cnt = 0, mod_p2_cnt = 0, dut_p1_cnt = 0, dut_p2_cnt = 0;

  ball_ctrl #(
    .BOARD_WIDTH  (W),
    .BOARD_HEIGHT (H),
    .PADDLE_HEIGHT(PH),
    .BALL_SPEED   (SPEED)
  ) dut (
    .clk              (clk),
    .i_rst            (i_rst),
    .i_game_active    (i_game_active),
    .i_paddle_y1      (i_paddle_y1),
    .i_paddle_y2      (i_paddle_y2),
    .i_col_counter_div(i_col_counter_div),
    .i_row_counter_div(i_row_counter_div),
    .o_ball_x         (o_ball_x),
    .o_ball_y         (o_ball_y),
    .o_draw_ball      (o_draw_ball),
    .o_p1_score       (o_p1_score),
    .o_p2_score       (o_p2_score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_centre();
    mx = W / 2;
    my = H / 2;
  endtask

  function automatic bit in_paddle(input int top, input int y);
    return (top <= y) && (y < top + PH);
  endfunction

  function automatic bit model_will_score();
    return mmoving && i_game_active && !i_rst && (mphase == SPEED - 1) &&
           ((mdx < 0 && mx == 0) || (mdx > 0 && mx == W - 1));
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int nx, ny, ndx, ndy;
    bit s1, s2;
    if (i_rst) begin
      mmoving = 0; model_centre(); mdx = 1; mdy = 1; mphase = 0;
      mp1 = 0; mp2 = 0; mdraw = 0;
      return;
    end
    mdraw = (int'(i_col_counter_div) == mx) && (int'(i_row_counter_div) == my);
    mp1 = 0;
    mp2 = 0;
    if (!mmoving) begin
      model_centre(); mphase = 0;
      if (i_game_active) mmoving = 1;
    end else if (!i_game_active) begin
      mmoving = 0; model_centre(); mphase = 0;
    end else if (mphase < SPEED - 1) begin
      mphase++;
    end else begin
      mphase = 0;
      ndy = mdy;
      ny  = my + mdy;
      if (ny < 0)      begin ny = 1;     ndy = 1;  end
      else if (ny > H - 1) begin ny = H - 2; ndy = -1; end
      s1 = 0; s2 = 0;
      ndx = mdx;
      nx  = mx + mdx;
      if (mdx < 0) begin
        if (mx == 0) s2 = 1;
        else if (mx == 1 && in_paddle(int'(i_paddle_y1), my)) begin ndx = 1; nx = 2; end
      end else begin
        if (mx == W - 1) s1 = 1;
        else if (mx == W - 2 && in_paddle(int'(i_paddle_y2), my)) begin ndx = -1; nx = W - 3; end
      end
      if (s1 || s2) begin
        mp1 = s1; mp2 = s2;
        mod_p1_cnt += int'(s1);
        mod_p2_cnt += int'(s2);
        mmoving = 0; model_centre();
        mdx = s2 ? 1 : -1;
      end else begin
        mx = nx; my = ny; mdx = ndx; mdy = ndy;
      end
    end
  endtask

  task automatic compare_all();
    chk("ball_x", 32'(o_ball_x), 32'(mx));
    chk("ball_y", 32'(o_ball_y), 32'(my));
    chk("draw_ball", 32'(o_draw_ball), 32'(mdraw));
    chk("p1_score", 32'(o_p1_score), 32'(mp1));
    chk("p2_score", 32'(o_p2_score), 32'(mp2));
    chk("score_exclusive", 32'(o_p1_score & o_p2_score), 32'd0);
    dut_p1_cnt += int'(o_p1_score === 1'b1);
    dut_p2_cnt += int'(o_p2_score === 1'b1);
  endtask

  // One edge: update the model for the driven inputs, then sample mid-cycle.
  task automatic tick();
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [5:0] paddle_for(input int y);
    int p;
    case ($urandom_range(0, 7))
      0, 1:    p = (y >= 12) ? 0 : H - PH;
      2:       p = int'($urandom_range(0, H - PH));
      default: p = y - int'($urandom_range(0, PH - 1));
    endcase
    if (p < 0) p = 0;
    if (p > H - PH) p = H - PH;
    return 6'(p);
  endfunction

  initial begin
    bit rst_score_done;
    rst_score_done    = 0;
    i_rst             = 1'b1;
    i_game_active     = 1'b0;
    i_paddle_y1       = 6'd12;
    i_paddle_y2       = 6'd12;
    i_col_counter_div = 6'd0;
    i_row_counter_div = 6'd0;
    mx = 0; my = 0; mdx = 1; mdy = 1; mphase = 0;
    mmoving = 0; mp1 = 0; mp2 = 0; mdraw = 0;

    tick();
    tick();
    chk("reset_x", 32'(o_ball_x), 32'd20);
    chk("reset_y", 32'(o_ball_y), 32'd15);
    chk("reset_draw", 32'(o_draw_ball), 32'd0);
    chk("reset_p1", 32'(o_p1_score), 32'd0);
    chk("reset_p2", 32'(o_p2_score), 32'd0);

    i_rst = 1'b0;
    tick();
    chk("idle_parked_x", 32'(o_ball_x), 32'd20);

    // Activation edge, then four counting cycles before the first step lands.
    i_game_active = 1'b1;
    tick();
    for (int i = 0; i < SPEED; i++) begin
      tick();
      if (i < SPEED - 1) begin
        chk("pre_step_x", 32'(o_ball_x), 32'd20);
        chk("pre_step_y", 32'(o_ball_y), 32'd15);
      end else begin
        chk("first_step_x", 32'(o_ball_x), 32'd21);
        chk("first_step_y", 32'(o_ball_y), 32'd16);
      end
    end

    // Scan hits the ball tile: draw one cycle later only.
    i_col_counter_div = o_ball_x;
    i_row_counter_div = o_ball_y;
    tick();
    chk("draw_on_tile", 32'(o_draw_ball), 32'd1);
    i_col_counter_div = o_ball_x + 6'd1;
    tick();
    chk("draw_off_tile", 32'(o_draw_ball), 32'd0);

    // Dropping game_active mid-flight re-centres with no score.
    i_game_active = 1'b0;
    tick();
    chk("abort_x", 32'(o_ball_x), 32'd20);
    chk("abort_y", 32'(o_ball_y), 32'd15);
    chk("abort_no_score", 32'(o_p1_score | o_p2_score), 32'd0);

    for (int cyc = 0; cyc < 12000; cyc++) begin
      i_rst = 1'b0;
      if (!mmoving) i_game_active = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 599) == 0) i_game_active = 1'b0;
      else i_game_active = 1'b1;
      i_paddle_y1 = paddle_for(my);
      i_paddle_y2 = paddle_for(my);
      case ($urandom_range(0, 3))
        0, 1: begin i_col_counter_div = 6'(mx); i_row_counter_div = 6'(my); end
        2:    begin i_col_counter_div = 6'(mx + 1); i_row_counter_div = 6'(my); end
        default: begin
          i_col_counter_div = 6'($urandom_range(0, 63));
          i_row_counter_div = 6'($urandom_range(0, 63));
        end
      endcase
      if (!rst_score_done && cyc > 3000 && model_will_score()) begin
        i_rst = 1'b1;
        rst_score_done = 1;
        tick();
        chk("rst_on_score_no_pulse", 32'(o_p1_score | o_p2_score), 32'd0);
        chk("rst_on_score_x", 32'(o_ball_x), 32'd20);
      end else begin
        tick();
      end
    end

    chk("p1_score_count", 32'(dut_p1_cnt), 32'(mod_p1_cnt));
    chk("p2_score_count", 32'(dut_p2_cnt), 32'(mod_p2_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
